// File: rtl/spi_pkg.sv
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared mode encodings, width bounds and FSM state for the SPI slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int SPI_DATA_W_MIN = 2;
  localparam int SPI_DATA_W_MAX = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// Module   : spi_sync_edge
// Purpose  : N-stage input synchroniser with a history flop for edge pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~hist_q;
  assign fall_o = ~sync_q[STAGES-1] & hist_q;

endmodule

`default_nettype wire

// File: rtl/spi_slave_duplex.sv
// ============================================================================
// Module   : spi_slave_duplex
// Purpose  : Oversampled full-duplex SPI slave, any CPOL/CPHA, either bit order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_duplex
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              spi_clk_i,
  input  logic              mosi_i,
  input  logic              spi_ss_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic [DATA_W-1:0] data_o,
  output logic              data_en_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              busy_o,
  output logic              frame_err_o,
  output logic              tx_underrun_o
);

  localparam int              CNT_W        = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DATA_W - 1);
  localparam logic [1:0]      MODE         = {1'(CPOL), 1'(CPHA)};
  localparam logic            LEAD_IS_RISE = (MODE == SPI_MODE0) || (MODE == SPI_MODE1);

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic ss_rise, ss_fall, ss_level_unused;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'(CPOL))) u_sync_sclk (
    .clk    (clk),
    .rstn   (rstn),
    .d_i    (spi_clk_i),
    .q_o    (sclk_level_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk    (clk),
    .rstn   (rstn),
    .d_i    (spi_ss_i),
    .q_o    (ss_level_unused),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk    (clk),
    .rstn   (rstn),
    .d_i    (mosi_i),
    .q_o    (mosi_sync),
    .rise_o (mosi_rise_unused),
    .fall_o (mosi_fall_unused)
  );

  logic lead_edge, trail_edge, sample_edge, shift_edge;

  assign lead_edge   = LEAD_IS_RISE ? sclk_rise : sclk_fall;
  assign trail_edge  = LEAD_IS_RISE ? sclk_fall : sclk_rise;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge  : trail_edge;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              data_en_q, data_en_d;
  logic              miso_q, miso_d;
  logic              ferr_q, ferr_d;
  logic              und_q, und_d;

  logic              word_start;
  logic [DATA_W-1:0] rx_next, tx_shifted, tx_load;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    data_d     = data_q;
    data_en_d  = 1'b0;
    miso_d     = miso_q;
    ferr_d     = 1'b0;
    und_d      = 1'b0;
    word_start = 1'b0;
    tx_load    = '0;
    tx_shifted = shift_out(tx_q);
    rx_next    = (MSB_FIRST != 0) ? {rx_q[DATA_W-2:0], mosi_sync}
                                  : {mosi_sync, rx_q[DATA_W-1:1]};

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d    = ACTIVE;
          cnt_d      = '0;
          word_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
          ferr_d  = (cnt_q != '0);
          cnt_d   = '0;
        end else if (sample_edge) begin
          rx_d = rx_next;
          if (cnt_q == CNT_LAST) begin
            data_d     = rx_next;
            data_en_d  = 1'b1;
            cnt_d      = '0;
            word_start = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (shift_edge) begin
          if (CPHA != 0) begin
            miso_d = first_bit(tx_q);
            tx_d   = tx_shifted;
          end else if (cnt_q != '0) begin
            // cnt_q==0 here means the word just wrapped: the fresh load already drives MISO
            tx_d   = tx_shifted;
            miso_d = first_bit(tx_shifted);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (word_start) begin
      if (hold_vld_q) begin
        tx_load    = hold_q;
        hold_vld_d = 1'b0;
      end else begin
        und_d = 1'b1;
      end
      tx_d = tx_load;
      if (CPHA == 0) begin
        miso_d = first_bit(tx_load);
      end
    end

    // Only reachable when the register was empty, so a same-cycle load cannot lose it
    if (tx_valid_i && !hold_vld_q) begin
      hold_d     = tx_data_i;
      hold_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      data_q     <= '0;
      data_en_q  <= 1'b0;
      miso_q     <= 1'b0;
      ferr_q     <= 1'b0;
      und_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      data_q     <= data_d;
      data_en_q  <= data_en_d;
      miso_q     <= miso_d;
      ferr_q     <= ferr_d;
      und_q      <= und_d;
    end
  end

  assign miso_o        = miso_q;
  assign miso_oe_o     = (state_q == ACTIVE);
  assign busy_o        = (state_q == ACTIVE);
  assign data_o        = data_q;
  assign data_en_o     = data_en_q;
  assign tx_ready_o    = ~hold_vld_q;
  assign frame_err_o   = ferr_q;
  assign tx_underrun_o = und_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_duplex.sv
// ============================================================================
// Module   : tb_spi_slave_duplex
// Purpose  : Directed bench: four 8-bit mode instances plus a 16-bit LSB-first one.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_duplex;

  localparam int HP = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ph = 1'b0;
  logic        ss = 1'b1;
  logic        mosi = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic [15:0] tx_data = 16'h0;
  logic        tx_valid = 1'b0;

  always #5 clk = ~clk;

  logic [4:0]       miso_v, oe_v, en_v, rdy_v, busy_v, ferr_v, und_v;
  logic [3:0][7:0]  d8;
  logic [15:0]      d16;

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_mode
      spi_slave_duplex #(
        .DATA_W(8), .SYNC_STAGES(2), .CPOL(k / 2), .CPHA(k % 2), .MSB_FIRST(1)
      ) u_dut (
        .clk           (clk),
        .rstn          (rstn),
        .spi_clk_i     ((sel == 3'(k)) ? (ph ^ 1'(k / 2)) : 1'(k / 2)),
        .mosi_i        (mosi),
        .spi_ss_i      ((sel == 3'(k)) ? ss : 1'b1),
        .miso_o        (miso_v[k]),
        .miso_oe_o     (oe_v[k]),
        .data_o        (d8[k]),
        .data_en_o     (en_v[k]),
        .tx_data_i     (tx_data[7:0]),
        .tx_valid_i    ((sel == 3'(k)) ? tx_valid : 1'b0),
        .tx_ready_o    (rdy_v[k]),
        .busy_o        (busy_v[k]),
        .frame_err_o   (ferr_v[k]),
        .tx_underrun_o (und_v[k])
      );
    end
  endgenerate

  spi_slave_duplex #(
    .DATA_W(16), .SYNC_STAGES(2), .CPOL(0), .CPHA(0), .MSB_FIRST(0)
  ) u_dut16 (
    .clk           (clk),
    .rstn          (rstn),
    .spi_clk_i     ((sel == 3'd4) ? ph : 1'b0),
    .mosi_i        (mosi),
    .spi_ss_i      ((sel == 3'd4) ? ss : 1'b1),
    .miso_o        (miso_v[4]),
    .miso_oe_o     (oe_v[4]),
    .data_o        (d16),
    .data_en_o     (en_v[4]),
    .tx_data_i     (tx_data),
    .tx_valid_i    ((sel == 3'd4) ? tx_valid : 1'b0),
    .tx_ready_o    (rdy_v[4]),
    .busy_o        (busy_v[4]),
    .frame_err_o   (ferr_v[4]),
    .tx_underrun_o (und_v[4])
  );

  logic        m_miso, m_oe, m_en, m_rdy, m_busy, m_ferr, m_und;
  logic [15:0] m_data;

  always_comb begin
    m_miso = miso_v[sel];
    m_oe   = oe_v[sel];
    m_en   = en_v[sel];
    m_rdy  = rdy_v[sel];
    m_busy = busy_v[sel];
    m_ferr = ferr_v[sel];
    m_und  = und_v[sel];
    m_data = (sel == 3'd4) ? d16 : {8'h00, d8[sel[1:0]]};
  end

  int          en_cnt = 0;
  int          ferr_cnt = 0;
  int          und_cnt = 0;
  logic [15:0] rx_log [8];

  always @(negedge clk) begin
    if (m_en) begin
      rx_log[en_cnt % 8] = m_data;
      en_cnt++;
    end
    if (m_ferr) ferr_cnt++;
    if (m_und) und_cnt++;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tx_write(input logic [15:0] v);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = v;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // SPI master: drives nbits from w0 then w1, records what it samples on MISO
  task automatic xfer(input logic [31:0] w0, input logic [31:0] w1, input int nbits,
                      input logic [15:0] tx1, input logic tx1_en,
                      input logic [15:0] inj, input logic inj_en,
                      input logic release_ss,
                      output logic [15:0] mo0, output logic [15:0] mo1,
                      output int und_start, output logic rdy_start);
    int          w;
    logic        cpha, msb, mbit;
    logic [31:0] word;
    int          wi, b, idx;
    w    = (sel == 3'd4) ? 16 : 8;
    cpha = (sel != 3'd4) && sel[0];
    msb  = (sel != 3'd4);
    mo0  = '0;
    mo1  = '0;
    @(negedge clk);
    ss = 1'b0;
    if (inj_en) begin
      repeat (2) @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = inj;
      @(negedge clk);
      tx_valid = 1'b0;
    end
    repeat (2 * HP) @(negedge clk);
    und_start = und_cnt;
    rdy_start = m_rdy;
    for (int i = 0; i < nbits; i++) begin
      wi   = i / w;
      b    = i % w;
      idx  = msb ? (w - 1 - b) : b;
      word = (wi == 0) ? w0 : w1;
      if (!cpha) begin
        mosi = word[idx];
        repeat (HP) @(negedge clk);
        ph   = 1'b1;
        mbit = m_miso;
        repeat (HP) @(negedge clk);
        ph   = 1'b0;
      end else begin
        ph   = 1'b1;
        mosi = word[idx];
        repeat (HP) @(negedge clk);
        ph   = 1'b0;
        mbit = m_miso;
        repeat (HP) @(negedge clk);
      end
      if (wi == 0) mo0[idx] = mbit;
      else         mo1[idx] = mbit;
      if (tx1_en && i == 0) tx_write(tx1);
    end
    if (release_ss) begin
      repeat (HP) @(negedge clk);
      ss = 1'b1;
      repeat (3 * HP) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [7:0]  tx;
    logic [7:0]  mosi_word;
    logic [7:0]  exp_rx;
    logic [7:0]  exp_miso;
  } vec_t;

  vec_t vecs [6];

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miso"},  32'(m_miso), 32'h0);
    chk({tag, "_oe"},    32'(m_oe),   32'h0);
    chk({tag, "_data"},  32'(m_data), 32'h0);
    chk({tag, "_en"},    32'(m_en),   32'h0);
    chk({tag, "_rdy"},   32'(m_rdy),  32'h1);
    chk({tag, "_busy"},  32'(m_busy), 32'h0);
    chk({tag, "_ferr"},  32'(m_ferr), 32'h0);
    chk({tag, "_und"},   32'(m_und),  32'h0);
  endtask

  initial begin
    logic [15:0] mo0, mo1;
    int          us, e0, f0, u0;
    logic        rs;

    vecs[0] = '{3'd0, 8'h3C, 8'hA5, 8'hA5, 8'h3C};
    vecs[1] = '{3'd1, 8'h96, 8'h96, 8'h96, 8'h96};
    vecs[2] = '{3'd2, 8'h96, 8'h96, 8'h96, 8'h96};
    vecs[3] = '{3'd3, 8'h96, 8'h96, 8'h96, 8'h96};
    vecs[4] = '{3'd0, 8'h81, 8'h7E, 8'h7E, 8'h81};
    vecs[5] = '{3'd3, 8'h5A, 8'hC3, 8'hC3, 8'h5A};

    repeat (4) @(negedge clk);
    chk_reset_outputs("reset");
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      sel = vecs[v].sel;
      tx_write({8'h00, vecs[v].tx});
      e0 = en_cnt;
      xfer({24'h0, vecs[v].mosi_word}, 32'h0, 8, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1,
           mo0, mo1, us, rs);
      chk($sformatf("v%0d_rx", v),      32'(rx_log[e0 % 8]), 32'(vecs[v].exp_rx));
      chk($sformatf("v%0d_miso", v),    32'(mo0),            32'(vecs[v].exp_miso));
      chk($sformatf("v%0d_en_cnt", v),  32'(en_cnt - e0),    32'd1);
      chk($sformatf("v%0d_rdy", v),     32'(rs),             32'h1);
    end

    // 16-bit LSB-first, two words in one frame; second tx word written mid-word
    sel = 3'd4;
    tx_write(16'hCAFE);
    e0 = en_cnt;
    xfer(32'h1234, 32'hBEEF, 32, 16'h0F0F, 1'b1, 16'h0, 1'b0, 1'b1, mo0, mo1, us, rs);
    chk("w16_en_cnt", 32'(en_cnt - e0),             32'd2);
    chk("w16_rx0",    32'(rx_log[e0 % 8]),          32'h1234);
    chk("w16_rx1",    32'(rx_log[(e0 + 1) % 8]),    32'hBEEF);
    chk("w16_miso0",  32'(mo0),                     32'hCAFE);
    chk("w16_miso1",  32'(mo1),                     32'h0F0F);

    // abort after 5 bits, then a clean frame
    sel = 3'd0;
    tx_write(16'h0011);
    e0 = en_cnt;
    f0 = ferr_cnt;
    xfer(32'hFF, 32'h0, 5, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, mo0, mo1, us, rs);
    chk("abort_ferr", 32'(ferr_cnt - f0), 32'd1);
    chk("abort_en",   32'(en_cnt - e0),   32'd0);
    tx_write(16'h0077);
    e0 = en_cnt;
    f0 = ferr_cnt;
    xfer(32'h5A, 32'h0, 8, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, mo0, mo1, us, rs);
    chk("after_abort_rx",   32'(rx_log[e0 % 8]), 32'h5A);
    chk("after_abort_miso", 32'(mo0),            32'h77);
    chk("after_abort_en",   32'(en_cnt - e0),    32'd1);
    chk("after_abort_ferr", 32'(ferr_cnt - f0),  32'd0);

    // underrun at frame start with empty holding register
    u0 = und_cnt;
    e0 = en_cnt;
    xfer(32'h33, 32'h0, 8, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, mo0, mo1, us, rs);
    chk("und_pulse", 32'(us - u0),         32'd1);
    chk("und_miso",  32'(mo0),             32'h00);
    chk("und_rx",    32'(rx_log[e0 % 8]),  32'h33);

    // write landing in the word-start cycle goes to the following word
    e0 = en_cnt;
    xfer(32'h21, 32'h4B, 16, 16'h0, 1'b0, 16'h00E7, 1'b1, 1'b1, mo0, mo1, us, rs);
    chk("inj_miso0", 32'(mo0),                   32'h00);
    chk("inj_miso1", 32'(mo1),                   32'hE7);
    chk("inj_rx1",   32'(rx_log[(e0 + 1) % 8]),  32'h4B);

    // reset in the middle of a word with a pending holding-register write
    tx_write(16'h0055);
    xfer(32'hFF, 32'h0, 4, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, mo0, mo1, us, rs);
    tx_write(16'h0066);
    chk("pre_rst_rdy",  32'(m_rdy),  32'h0);
    chk("pre_rst_busy", 32'(m_busy), 32'h1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    ss   = 1'b1;
    ph   = 1'b0;
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    e0 = en_cnt;
    f0 = ferr_cnt;
    xfer(32'hC3, 32'h0, 8, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, mo0, mo1, us, rs);
    chk("post_rst_rx",   32'(rx_log[e0 % 8]), 32'hC3);
    chk("post_rst_en",   32'(en_cnt - e0),    32'd1);
    chk("post_rst_ferr", 32'(ferr_cnt - f0),  32'd0);
    chk("post_rst_miso", 32'(mo0),            32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
